clock_monitor: RTL and testbench

Frequency checker for the divided clocks: samples one slow clock (`clk_10KHz` or `clk_100KHz`) in the `clock1M` domain and measures every half-period in `clock1M` cycles. It declares lock after a run of in-tolerance measurements and flags deviations or a stopped clock. One instance sits beside each divider output. It acts as the consuming/reading end of that output and is used for board bring-up and runtime clock health.

---
 rtl/clock_monitor.sv | 165 ++++++++++++++++
 tb/tb_clock_monitor.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/clock_monitor.sv
// Half-period monitor for a slow divided clock sampled in the clock1M domain.
// Publishes each half-period measurement, tracks lock and raises sticky errors and timeouts.
module clock_monitor #(
  parameter int EXP_HALF   = 50,
  parameter int TOL        = 1,
  parameter int LOCK_COUNT = 4,
  parameter int CW         = 8
) (
  input  logic          clock1M,
  input  logic          reset,
  input  logic          clk_in,
  input  logic          err_clr,
  output logic [CW-1:0] half_period,
  output logic          meas_valid,
  output logic          locked,
  output logic          err,
  output logic          timeout
);

  localparam int GW = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  localparam logic [CW-1:0] TMO      = CW'(2 * EXP_HALF);
  localparam logic [GW-1:0] GOOD_ONE = GW'(1);
  localparam logic [GW-1:0] GOOD_TGT = GW'(LOCK_COUNT);
  localparam logic [31:0]   LO32     = (EXP_HALF > TOL) ? 32'(EXP_HALF - TOL) : 32'd0;
  localparam logic [31:0]   HI32     = 32'(EXP_HALF + TOL);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t        state, state_next;
  logic [GW-1:0] good, good_next;
  logic [GW-1:0] good_inc;
  logic          s1, s2, s3;
  logic          edge_evt;
  logic [CW-1:0] cnt;
  logic          meas_good;
  logic          timeout_hit;
  logic          publish;
  logic          tmo_evt;
  logic          err_set;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  // Full-width unsigned window test; a saturated count always lands outside it.
  function automatic logic in_tol(input logic [CW-1:0] m);
    logic [31:0] mu;
    mu = 32'(m);
    return (mu >= LO32) && (mu <= HI32);
  endfunction

  assign meas_good   = in_tol(cnt);
  assign timeout_hit = (cnt >= TMO);
  assign good_inc    = good + GOOD_ONE;

  // Stage 0: synchronizer, delay flop, registered edge event and interval counter
  always_ff @(posedge clock1M or negedge reset) begin
    if (!reset) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      s3       <= 1'b0;
      edge_evt <= 1'b0;
      cnt      <= '0;
    end else begin
      s1       <= clk_in;
      s2       <= s1;
      s3       <= s2;
      edge_evt <= s2 ^ s3;
      cnt      <= edge_evt ? CNT_ONE : sat_inc(cnt);
    end
  end

  always_ff @(posedge clock1M or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      good  <= '0;
    end else begin
      state <= state_next;
      good  <= good_next;
    end
  end

  always_comb begin
    state_next = state;
    good_next  = good;
    unique case (state)
      IDLE: begin
        if (edge_evt) begin
          state_next = ACQ;
          good_next  = '0;
        end
      end
      ACQ: begin
        if (edge_evt) begin
          if (meas_good) begin
            good_next = good_inc;
            if (good_inc == GOOD_TGT) state_next = LOCKED;
          end else begin
            good_next = '0;
          end
        end else if (timeout_hit) begin
          state_next = IDLE;
          good_next  = '0;
        end
      end
      LOCKED: begin
        if (edge_evt) begin
          if (!meas_good) begin
            state_next = ACQ;
            good_next  = '0;
          end
        end else if (timeout_hit) begin
          state_next = IDLE;
          good_next  = '0;
        end
      end
      default: begin
        state_next = IDLE;
        good_next  = '0;
      end
    endcase
  end

  // An edge arriving in the timeout cycle takes precedence and is measured normally.
  always_comb begin
    publish = 1'b0;
    tmo_evt = 1'b0;
    err_set = 1'b0;
    if (state != IDLE) begin
      publish = edge_evt;
      tmo_evt = !edge_evt && timeout_hit;
    end
    if (state == LOCKED) begin
      err_set = (edge_evt && !meas_good) || (!edge_evt && timeout_hit);
    end
  end

  // Stage 1: registered outputs; locked follows the next state so it rises with meas_valid
  always_ff @(posedge clock1M or negedge reset) begin
    if (!reset) begin
      half_period <= '0;
      meas_valid  <= 1'b0;
      locked      <= 1'b0;
      err         <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      meas_valid <= publish;
      timeout    <= tmo_evt;
      locked     <= (state_next == LOCKED);
      if (publish) half_period <= cnt;
      if (err_set) begin
        err <= 1'b1;
      end else if (err_clr) begin
        err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_clock_monitor.sv
// Directed bench for clock_monitor: a 10 kHz-style instance (EXP_HALF=50)
// and a 100 kHz-style instance (EXP_HALF=5) sharing one clock1M.
module tb_clock_monitor;

  logic       clock1M;
  logic       reset_a, reset_b;
  logic       clk_a, clk_b;
  logic       clr_a, clr_b;
  logic [7:0] hp_a, hp_b;
  logic       mv_a, mv_b;
  logic       lk_a, lk_b;
  logic       er_a, er_b;
  logic       to_a, to_b;

  int n_tests = 0;
  int n_fail  = 0;

  clock_monitor #(.EXP_HALF(50), .TOL(1), .LOCK_COUNT(4), .CW(8)) dut_a (
    .clock1M(clock1M), .reset(reset_a), .clk_in(clk_a), .err_clr(clr_a),
    .half_period(hp_a), .meas_valid(mv_a), .locked(lk_a), .err(er_a), .timeout(to_a)
  );

  clock_monitor #(.EXP_HALF(5), .TOL(1), .LOCK_COUNT(4), .CW(8)) dut_b (
    .clock1M(clock1M), .reset(reset_b), .clk_in(clk_b), .err_clr(clr_b),
    .half_period(hp_b), .meas_valid(mv_b), .locked(lk_b), .err(er_b), .timeout(to_b)
  );

  initial clock1M = 1'b0;
  always #5 clock1M = ~clock1M;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock1M);
      #1;
    end
  endtask

  // Toggle the monitored clock; its measurement appears 4 cycles later for one cycle.
  task automatic step_edge(input bit b, input string tag, input bit mv, input int hp,
                           input bit lk, input bit er);
    if (b) clk_b = ~clk_b;
    else   clk_a = ~clk_a;
    cyc(4);
    chk({tag, ".mv"}, b ? 32'(mv_b) : 32'(mv_a), 32'(mv));
    if (mv) chk({tag, ".hp"}, b ? 32'(hp_b) : 32'(hp_a), 32'(hp));
    chk({tag, ".lk"}, b ? 32'(lk_b) : 32'(lk_a), 32'(lk));
    chk({tag, ".er"}, b ? 32'(er_b) : 32'(er_a), 32'(er));
    cyc(1);
    chk({tag, ".mv_off"}, b ? 32'(mv_b) : 32'(mv_a), 32'd0);
  endtask

  task automatic edge_hold(input bit b, input string tag, input int len, input bit mv,
                           input int hp, input bit lk, input bit er);
    step_edge(b, tag, mv, hp, lk, er);
    cyc(len - 5);
  endtask

  initial begin
    reset_a = 1'b0;
    reset_b = 1'b0;
    clk_a   = 1'b0;
    clk_b   = 1'b0;
    clr_a   = 1'b0;
    clr_b   = 1'b0;
    cyc(2);

    // Reset held while the monitored clock toggles
    for (int i = 0; i < 4; i++) begin
      clk_a = ~clk_a;
      cyc(3);
      chk("rst.hp", 32'(hp_a), 32'd0);
      chk("rst.mv", 32'(mv_a), 32'd0);
      chk("rst.lk", 32'(lk_a), 32'd0);
      chk("rst.er", 32'(er_a), 32'd0);
      chk("rst.to", 32'(to_a), 32'd0);
    end
    reset_a = 1'b1;
    cyc(10);
    chk("rel.mv", 32'(mv_a), 32'd0);
    chk("rel.lk", 32'(lk_a), 32'd0);

    // Acquire at 50 and lock on the fifth edge
    edge_hold(0, "e1", 50, 0, 0, 0, 0);
    edge_hold(0, "e2", 50, 1, 50, 0, 0);
    edge_hold(0, "e3", 50, 1, 50, 0, 0);
    edge_hold(0, "e4", 50, 1, 50, 0, 0);
    edge_hold(0, "e5", 49, 1, 50, 1, 0);
    // Tolerance edges 49/51 keep lock, 52 drops it
    edge_hold(0, "e6", 51, 1, 49, 1, 0);
    edge_hold(0, "e7", 50, 1, 51, 1, 0);
    edge_hold(0, "e8", 52, 1, 50, 1, 0);
    edge_hold(0, "e9", 50, 1, 52, 0, 1);
    edge_hold(0, "e10", 50, 1, 50, 0, 1);
    edge_hold(0, "e11", 50, 1, 50, 0, 1);
    edge_hold(0, "e12", 50, 1, 50, 0, 1);
    edge_hold(0, "e13", 50, 1, 50, 1, 1);

    // err_clr alone clears the sticky flag
    step_edge(0, "e14", 1, 50, 1, 1);
    clr_a = 1'b1;
    cyc(1);
    clr_a = 1'b0;
    chk("clr.er", 32'(er_a), 32'd0);
    cyc(44);
    edge_hold(0, "e15", 53, 1, 50, 1, 0);

    // err_clr coincident with a bad measurement: set wins, then clear next cycle
    clk_a = ~clk_a;
    cyc(3);
    clr_a = 1'b1;
    cyc(1);
    chk("e16.mv", 32'(mv_a), 32'd1);
    chk("e16.hp", 32'(hp_a), 32'd53);
    chk("e16.lk", 32'(lk_a), 32'd0);
    chk("e16.er_set_wins", 32'(er_a), 32'd1);
    cyc(1);
    chk("e16.er_clr", 32'(er_a), 32'd0);
    clr_a = 1'b0;
    cyc(45);
    edge_hold(0, "e17", 50, 1, 50, 0, 0);
    edge_hold(0, "e18", 50, 1, 50, 0, 0);
    edge_hold(0, "e19", 50, 1, 50, 0, 0);

    // Stop the monitored clock while locked
    step_edge(0, "e20", 1, 50, 1, 0);
    cyc(98);
    chk("tmo.pre_to", 32'(to_a), 32'd0);
    chk("tmo.pre_lk", 32'(lk_a), 32'd1);
    chk("tmo.pre_er", 32'(er_a), 32'd0);
    cyc(1);
    chk("tmo.to", 32'(to_a), 32'd1);
    chk("tmo.lk", 32'(lk_a), 32'd0);
    chk("tmo.er", 32'(er_a), 32'd1);
    cyc(1);
    chk("tmo.to_off", 32'(to_a), 32'd0);

    // Restart: first edge re-arms from IDLE, four more relock
    edge_hold(0, "e21", 50, 0, 0, 0, 1);
    edge_hold(0, "e22", 50, 1, 50, 0, 1);
    edge_hold(0, "e23", 50, 1, 50, 0, 1);
    edge_hold(0, "e24", 50, 1, 50, 0, 1);
    step_edge(0, "e25", 1, 50, 1, 1);

    // Fast instance at EXP_HALF=5
    reset_b = 1'b1;
    cyc(3);
    edge_hold(1, "f1", 5, 0, 0, 0, 0);
    edge_hold(1, "f2", 5, 1, 5, 0, 0);
    edge_hold(1, "f3", 5, 1, 5, 0, 0);
    edge_hold(1, "f4", 5, 1, 5, 0, 0);
    edge_hold(1, "f5", 5, 1, 5, 1, 0);
    chk("f.lk_before_rst", 32'(lk_b), 32'd1);
    #2;
    reset_b = 1'b0;
    #1;
    chk("f.async_lk", 32'(lk_b), 32'd0);
    chk("f.async_hp", 32'(hp_b), 32'd0);
    chk("f.async_mv", 32'(mv_b), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
